// File: rtl/h75_fb_swap_ctrl_pkg.sv
// Shared types and defaults for the HUB75 framebuffer double-buffer sequencer.
// Optional clear engine is selected with H75_FB_CLEAR_EN.
package h75_pkg;

   localparam int H75_ADDR_W   = 14;
   localparam int H75_DATA_W   = 32;
   // Bank select sits directly above the per-bank word address.
   localparam int H75_BANK_BIT = H75_ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_CLEAR     = 2'd1,
      ST_WAIT_SYNC = 2'd2
   } h75_fbsc_state_t;

endpackage

// File: rtl/h75_fb_swap_ctrl_if.sv
// Host write port and framebuffer RAM write port of the swap sequencer.
// master = host/RAM side, slave = sequencer.
interface h75_fb_swap_ctrl_if
   import h75_pkg::*;
#(
   parameter int ADDR_W = H75_ADDR_W,
   parameter int DATA_W = H75_DATA_W
) ();

   logic              host_wr;
   logic [ADDR_W-1:0] host_waddr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_wr_ready;
   logic              host_wr_drop;

   logic              mem_wr;
   logic [ADDR_W:0]   mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      output host_wr, host_waddr, host_wdata,
      input  host_wr_ready, host_wr_drop,
      input  mem_wr, mem_waddr, mem_wdata
   );

   modport slave (
      input  host_wr, host_waddr, host_wdata,
      output host_wr_ready, host_wr_drop,
      output mem_wr, mem_waddr, mem_wdata
   );

endinterface

// File: rtl/h75_fb_clear_gen.sv
// Back-bank clear address counter with a registered last-word flag.
// Only instantiated when H75_FB_CLEAR_EN is defined.
module h75_fb_clear_gen
   import h75_pkg::*;
#(
   parameter int ADDR_W  = H75_ADDR_W,
   parameter int CLR_LEN = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CLR_LEN - 1);

   logic [ADDR_W-1:0] addr_d, addr_q;
   logic              done_d, done_q;

   // Counter parks on the last word instead of wrapping.
   always_comb begin
      addr_d = addr_q;
      if (start) begin
         addr_d = '0;
      end else if (step && !done_q) begin
         addr_d = addr_q + 1'b1;
      end
      done_d = (addr_d == LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         done_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         done_q <= done_d;
      end
   end

   assign addr = addr_q;
   assign done = done_q;

endmodule

// File: rtl/h75_fb_swap_ctrl.sv
// Double-buffer sequencer: host writes to back bank, swaps at frame boundary.
// Define H75_FB_CLEAR_EN to include the back-bank clear engine.
module h75_fb_swap_ctrl
   import h75_pkg::*;
#(
   parameter int ADDR_W  = H75_ADDR_W,
   parameter int DATA_W  = H75_DATA_W,
   parameter int CLR_LEN = 2**ADDR_W
) (
   input  logic                PCLK,
   input  logic                PRESETN,
   h75_fb_swap_ctrl_if.slave   bus,
   input  logic                swap_req,
   input  logic                clear_req,
   input  logic [DATA_W-1:0]   clear_value,
   input  logic                frame_sync,
   output logic                rd_bank,
   output logic                swap_pending,
   output logic                clear_busy,
   output logic                swap_done
);

   h75_fbsc_state_t   state_d, state_q;
   logic              fs_q;
   logic              rd_bank_d, rd_bank_q;
   logic              swap_pend_d, swap_pend_q;
   logic              swap_done_d, swap_done_q;
   logic              drop_d, drop_q;
   logic              mem_wr_d, mem_wr_q;
   logic [ADDR_W:0]   mem_waddr_d, mem_waddr_q;
   logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
   logic              ready;
   logic              accept;
   logic              rise;

`ifdef H75_FB_CLEAR_EN
   logic              ready_d, ready_q;
   logic              clr_pend_d, clr_pend_q;
   logic [DATA_W-1:0] clr_val_d, clr_val_q;
   logic              clr_start, clr_step;
   logic [ADDR_W-1:0] clr_addr;
   logic              clr_done;

   h75_fb_clear_gen #(
      .ADDR_W  (ADDR_W),
      .CLR_LEN (CLR_LEN)
   ) u_clear_gen (
      .clk   (PCLK),
      .rst_n (PRESETN),
      .start (clr_start),
      .step  (clr_step),
      .addr  (clr_addr),
      .done  (clr_done)
   );

   assign ready      = ready_q;
   assign clear_busy = clr_pend_q;
`else
   wire unused_clear = ^{clear_req, clear_value, CLR_LEN[0]};

   assign ready      = 1'b1;
   assign clear_busy = 1'b0;
`endif

   assign rise   = frame_sync & ~fs_q;
   assign accept = bus.host_wr & ready;

   always_comb begin
      state_d     = state_q;
      rd_bank_d   = rd_bank_q;
      swap_pend_d = swap_pend_q | swap_req;
      swap_done_d = 1'b0;
      drop_d      = bus.host_wr & ~ready;
      // Bank is taken from rd_bank as it stands at acceptance.
      mem_wr_d    = accept;
      mem_waddr_d = {~rd_bank_q, bus.host_waddr};
      mem_wdata_d = bus.host_wdata;
`ifdef H75_FB_CLEAR_EN
      clr_pend_d  = clr_pend_q | clear_req;
      clr_val_d   = clr_val_q;
      clr_start   = 1'b0;
      clr_step    = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
`ifdef H75_FB_CLEAR_EN
            if (clr_pend_q) begin
               state_d   = ST_CLEAR;
               clr_start = 1'b1;
               clr_val_d = clear_value;
            end else
`endif
            if (swap_pend_q) begin
               state_d = ST_WAIT_SYNC;
            end
         end
`ifdef H75_FB_CLEAR_EN
         ST_CLEAR: begin
            clr_step    = 1'b1;
            mem_wr_d    = 1'b1;
            mem_waddr_d = {~rd_bank_q, clr_addr};
            mem_wdata_d = clr_val_q;
            if (clr_done) begin
               clr_pend_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
`endif
         ST_WAIT_SYNC: begin
            if (rise) begin
               rd_bank_d   = ~rd_bank_q;
               swap_done_d = 1'b1;
               swap_pend_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef H75_FB_CLEAR_EN
      ready_d = (state_d != ST_CLEAR);
`endif
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q     <= ST_IDLE;
         fs_q        <= 1'b0;
         rd_bank_q   <= 1'b0;
         swap_pend_q <= 1'b0;
         swap_done_q <= 1'b0;
         drop_q      <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_waddr_q <= '0;
         mem_wdata_q <= '0;
`ifdef H75_FB_CLEAR_EN
         ready_q     <= 1'b0;
         clr_pend_q  <= 1'b0;
         clr_val_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         fs_q        <= frame_sync;
         rd_bank_q   <= rd_bank_d;
         swap_pend_q <= swap_pend_d;
         swap_done_q <= swap_done_d;
         drop_q      <= drop_d;
         mem_wr_q    <= mem_wr_d;
         mem_waddr_q <= mem_waddr_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef H75_FB_CLEAR_EN
         ready_q     <= ready_d;
         clr_pend_q  <= clr_pend_d;
         clr_val_q   <= clr_val_d;
`endif
      end
   end

   assign bus.host_wr_ready = ready;
   assign bus.host_wr_drop  = drop_q;
   assign bus.mem_wr        = mem_wr_q;
   assign bus.mem_waddr     = mem_waddr_q;
   assign bus.mem_wdata     = mem_wdata_q;
   assign rd_bank           = rd_bank_q;
   assign swap_pending      = swap_pend_q;
   assign swap_done         = swap_done_q;

endmodule

// File: tb/tb_h75_fb_swap_ctrl.sv
// Directed bench for h75_fb_swap_ctrl (ADDR_W=14, CLR_LEN=8).
// Clear scenarios run when H75_FB_CLEAR_EN is defined, else the tie-off scenario.
module tb_h75_fb_swap_ctrl;

   localparam int AW = 14;
   localparam int DW = 32;
   localparam int CL = 8;

   logic          PCLK = 1'b0;
   logic          PRESETN;
   logic          swap_req, clear_req, frame_sync;
   logic [DW-1:0] clear_value;
   logic          rd_bank, swap_pending, clear_busy, swap_done;

   int checks = 0;
   int errors = 0;
   int n, w, nr, nd;
   logic drove, found, fin;

   always #5 PCLK = ~PCLK;

   h75_fb_swap_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   h75_fb_swap_ctrl #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .CLR_LEN (CL)
   ) dut (
      .PCLK         (PCLK),
      .PRESETN      (PRESETN),
      .bus          (bus),
      .swap_req     (swap_req),
      .clear_req    (clear_req),
      .clear_value  (clear_value),
      .frame_sync   (frame_sync),
      .rd_bank      (rd_bank),
      .swap_pending (swap_pending),
      .clear_busy   (clear_busy),
      .swap_done    (swap_done)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      PRESETN = 1'b1;
      swap_req = 1'b0;
      clear_req = 1'b0;
      frame_sync = 1'b0;
      clear_value = '0;
      bus.host_wr = 1'b0;
      bus.host_waddr = '0;
      bus.host_wdata = '0;
      #2 PRESETN = 1'b0;
      #20;

      check("rst_mem_wr", bus.mem_wr, 0);
      check("rst_mem_waddr", bus.mem_waddr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_rd_bank", rd_bank, 0);
      check("rst_swap_pending", swap_pending, 0);
      check("rst_swap_done", swap_done, 0);
      check("rst_clear_busy", clear_busy, 0);
      check("rst_drop", bus.host_wr_drop, 0);
`ifdef H75_FB_CLEAR_EN
      check("rst_ready", bus.host_wr_ready, 0);
`else
      check("rst_ready", bus.host_wr_ready, 1);
`endif

      PRESETN = 1'b1;
      tick();
      check("ready_after_rst", bus.host_wr_ready, 1);

      // host write into back bank 1
      bus.host_wr = 1'b1;
      bus.host_waddr = 14'h0010;
      bus.host_wdata = 32'hA5A5A5A5;
      tick();
      bus.host_wr = 1'b0;
      check("t1_mem_wr", bus.mem_wr, 1);
      check("t1_mem_waddr", bus.mem_waddr, 15'h4010);
      check("t1_mem_wdata", bus.mem_wdata, 32'hA5A5A5A5);
      tick();
      check("t1_mem_wr_idle", bus.mem_wr, 0);

`ifdef H75_FB_CLEAR_EN
      // clear of bank 1 with a dropped host write in the middle
      clear_value = 32'h00FF00FF;
      clear_req = 1'b1;
      bus.host_waddr = 14'h3FFF;
      bus.host_wdata = 32'hDEADBEEF;
      tick();
      clear_req = 1'b0;
      check("t3_busy", clear_busy, 1);
      w = 0; nr = 0; nd = 0; drove = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (bus.mem_wr) begin
            check("t3_clr_addr", bus.mem_waddr, 64'h4000 + w);
            check("t3_clr_data", bus.mem_wdata, 32'h00FF00FF);
            w++;
         end
         nr += int'(!bus.host_wr_ready);
         nd += int'(bus.host_wr_drop);
         if (!bus.host_wr_ready && !drove) begin
            bus.host_wr = 1'b1;
            drove = 1'b1;
         end else begin
            bus.host_wr = 1'b0;
         end
         tick();
      end
      check("t3_writes", w, CL);
      check("t3_ready_low", nr, CL);
      check("t3_drops", nd, 1);
      check("t3_busy_end", clear_busy, 0);
      check("t3_ready_end", bus.host_wr_ready, 1);
`endif

      // swap 20 cycles after the request
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         n += int'(swap_pending);
         if (i == 10) check("t2_no_early_swap", rd_bank, 0);
         if (i == 19) frame_sync = 1'b1;
         tick();
      end
      check("t2_pending_cycles", n, 20);
      check("t2_pending_clr", swap_pending, 0);
      check("t2_swap_done", swap_done, 1);
      check("t2_rd_bank", rd_bank, 1);
      bus.host_wr = 1'b1;
      bus.host_waddr = 14'h0010;
      bus.host_wdata = 32'h5A5A5A5A;
      tick();
      bus.host_wr = 1'b0;
      check("t2_done_pulse", swap_done, 0);
      check("t2_mem_waddr", bus.mem_waddr, 15'h0010);
      check("t2_mem_wdata", bus.mem_wdata, 32'h5A5A5A5A);
      frame_sync = 1'b0;
      tick();

`ifdef H75_FB_CLEAR_EN
      // reset in the middle of a bank-0 clear with a swap queued
      clear_req = 1'b1;
      swap_req = 1'b1;
      tick();
      clear_req = 1'b0;
      swap_req = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (bus.mem_wr && bus.mem_waddr[2:0] == 3'd3) found = 1'b1;
      end
      check("t5_word3_seen", found, 1);
      check("t5_word3_addr", bus.mem_waddr, 15'h0003);
      #2 PRESETN = 1'b0;
      #1;
      check("t5_mem_wr", bus.mem_wr, 0);
      check("t5_mem_waddr", bus.mem_waddr, 0);
      check("t5_rd_bank", rd_bank, 0);
      check("t5_pending", swap_pending, 0);
      check("t5_busy", clear_busy, 0);
      check("t5_ready", bus.host_wr_ready, 0);
      #2 PRESETN = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         n += int'(bus.mem_wr);
      end
      check("t5_no_resume", n, 0);
      check("t5_busy_after", clear_busy, 0);
      check("t5_ready_after", bus.host_wr_ready, 1);

      // clear and swap together; edge during clear must not swap
      clear_value = 32'h00001234;
      clear_req = 1'b1;
      swap_req = 1'b1;
      tick();
      clear_req = 1'b0;
      swap_req = 1'b0;
      w = 0;
      fin = 1'b0;
      for (int i = 0; i < 30 && !fin; i++) begin
         if (i == 3) frame_sync = 1'b1;
         if (bus.mem_wr) begin
            check("t4_clr_addr", bus.mem_waddr, 64'h4000 + w);
            w++;
         end
         if (!clear_busy) fin = 1'b1;
         else tick();
      end
      check("t4_clear_end", fin, 1);
      check("t4_writes", w, CL);
      repeat (4) tick();
      check("t4_no_swap_bank", rd_bank, 0);
      check("t4_still_pending", swap_pending, 1);
      frame_sync = 1'b0;
      tick();
      frame_sync = 1'b1;
      tick();
      check("t4_swap_done", swap_done, 1);
      check("t4_rd_bank", rd_bank, 1);
      check("t4_pending_clr", swap_pending, 0);
      frame_sync = 1'b0;
      tick();
`else
      // clear requests are inert in this build
      clear_value = 32'h00FF00FF;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      n = 0; w = 0; nr = 0;
      for (int i = 0; i < 12; i++) begin
         n += int'(bus.mem_wr);
         w += int'(clear_busy);
         nr += int'(!bus.host_wr_ready);
         tick();
      end
      check("t6_no_mem_wr", n, 0);
      check("t6_busy_never", w, 0);
      check("t6_ready_always", nr, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
